// File: rtl/rv32i_types.sv
// Shared fetch-stage types: BTB entry layout, fetch_1 pipeline register, FSM states.
package rv32i_types;

   localparam int          BTB_DEPTH = 32;
   localparam logic [31:0] RESET_PC  = 32'h1eceb000;

   // Tag field sized for the smallest legal BTB so any power-of-two depth fits.
   localparam int BTB_TAG_W = 30;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           counter;
   } btb_entry_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        branch_pred;
   } fetch_reg_1_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_e;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken && ctr != 2'd3) begin
         res = ctr + 2'd1;
      end else if (!taken && ctr != 2'd0) begin
         res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookups read registered state only, so an update becomes visible one cycle later.
module btb #(
   parameter int DEPTH = rv32i_types::BTB_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc_i,
   output logic        pred_o,
   output logic [31:0] target_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic [31:0] upd_target_i,
   input  logic        upd_taken_i
);
   import rv32i_types::*;

   localparam int IDX_W = $clog2(DEPTH);

   btb_entry_t       mem_q [DEPTH];
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] up_idx;
   btb_entry_t       lk_e;
   btb_entry_t       up_e;
   btb_entry_t       up_d;
   logic             lk_hit;
   logic             up_hit;
   logic             up_we;
   logic             unused_lk_ctr0;

   function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
      return BTB_TAG_W'(pc >> (IDX_W + 2));
   endfunction

   assign lk_idx = lookup_pc_i[IDX_W+1:2];
   assign up_idx = upd_pc_i[IDX_W+1:2];

   assign lk_e     = mem_q[lk_idx];
   assign lk_hit   = lk_e.valid && (lk_e.tag == tag_of(lookup_pc_i));
   assign pred_o   = lk_hit && lk_e.counter[1];
   assign target_o = lk_e.target;

   assign unused_lk_ctr0 = lk_e.counter[0];

   always_comb begin
      up_e   = mem_q[up_idx];
      up_hit = up_e.valid && (up_e.tag == tag_of(upd_pc_i));
      up_we  = 1'b0;
      up_d   = up_e;
      if (upd_valid_i) begin
         if (up_hit) begin
            up_we        = 1'b1;
            up_d.counter = sat_update(up_e.counter, upd_taken_i);
            if (upd_taken_i) begin
               up_d.target = upd_target_i;
            end
         end else if (upd_taken_i) begin
            // Taken miss claims the slot, starting weakly taken.
            up_we        = 1'b1;
            up_d.valid   = 1'b1;
            up_d.tag     = tag_of(upd_pc_i);
            up_d.target  = upd_target_i;
            up_d.counter = 2'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (up_we) begin
         mem_q[up_idx] <= up_d;
      end
   end

endmodule

// File: rtl/fetch_1.sv
// First fetch stage: PC generation with BTB prediction and mispredict drain.
//   state    | meaning
//   ST_RUN   | issue pc_q each unstalled cycle
//   ST_DRAIN | request flushed while in flight; wait for its response and drop it
module fetch_1 #(
   parameter int          BTB_DEPTH = rv32i_types::BTB_DEPTH,
   parameter logic [31:0] RESET_PC  = rv32i_types::RESET_PC
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      imem_stall,
   input  logic                      imem_resp,
   input  logic                      branch_mispredict,
   input  logic [31:0]               redirect_pc,
   input  logic                      upd_valid,
   input  logic [31:0]               upd_pc,
   input  logic [31:0]               upd_target,
   input  logic                      upd_taken,
   output logic [31:0]               imem_addr,
   output logic [3:0]                imem_rmask,
   output rv32i_types::fetch_reg_1_t fetch_1_reg
);
   import rv32i_types::*;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   fetch_reg_1_t reg_q, reg_d;
   logic         pred;
   logic [31:0]  pred_target;
   logic [31:0]  next_pc;
   logic [3:0]   rmask;

   btb #(
      .DEPTH(BTB_DEPTH)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .lookup_pc_i (pc_q),
      .pred_o      (pred),
      .target_o    (pred_target),
      .upd_valid_i (upd_valid),
      .upd_pc_i    (upd_pc),
      .upd_target_i(upd_target),
      .upd_taken_i (upd_taken)
   );

   assign next_pc = pred ? pred_target : pc_q + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      reg_d   = reg_q;
      rmask   = 4'h0;
      if (branch_mispredict) begin
         pc_d        = redirect_pc;
         reg_d.valid = 1'b0;
         if (state_q == ST_RUN && reg_q.valid && !imem_resp) begin
            state_d = ST_DRAIN;
         end
      end else if (state_q == ST_DRAIN) begin
         reg_d.valid = 1'b0;
         if (imem_resp) begin
            state_d = ST_RUN;
         end
      end else if (!imem_stall) begin
         rmask             = 4'hF;
         reg_d.valid       = 1'b1;
         reg_d.pc          = pc_q;
         reg_d.branch_pred = pred;
         pc_d              = next_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         reg_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         reg_q   <= reg_d;
      end
   end

   assign imem_addr   = pc_q;
   assign imem_rmask  = rst ? 4'h0 : rmask;
   assign fetch_1_reg = reg_q;

endmodule

// File: tb/tb_fetch_1.sv
// Directed scenarios plus a randomized run against a behavioural fetch/BTB model.
module tb_fetch_1;
   import rv32i_types::*;

   localparam logic [31:0] RPC = 32'h1eceb000;

   logic         clk = 1'b0;
   logic         rst;
   logic         imem_stall, imem_resp, branch_mispredict;
   logic [31:0]  redirect_pc;
   logic         upd_valid, upd_taken;
   logic [31:0]  upd_pc, upd_target;
   logic [31:0]  imem_addr;
   logic [3:0]   imem_rmask;
   fetch_reg_1_t fetch_1_reg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_1 dut (
      .clk              (clk),
      .rst              (rst),
      .imem_stall       (imem_stall),
      .imem_resp        (imem_resp),
      .branch_mispredict(branch_mispredict),
      .redirect_pc      (redirect_pc),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_target       (upd_target),
      .upd_taken        (upd_taken),
      .imem_addr        (imem_addr),
      .imem_rmask       (imem_rmask),
      .fetch_1_reg      (fetch_1_reg)
   );

   task automatic idle();
      imem_stall        = 1'b0;
      imem_resp         = 1'b0;
      branch_mispredict = 1'b0;
      redirect_pc       = '0;
      upd_valid         = 1'b0;
      upd_pc            = '0;
      upd_target        = '0;
      upd_taken         = 1'b0;
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      clk_step();
      clk_step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      clk_step();
      clk_step();
      checks += 3;
      if (imem_addr !== RPC) begin failures++; $display("FAIL rst_addr got %h want %h", imem_addr, RPC); end
      if (imem_rmask !== 4'h0) begin failures++; $display("FAIL rst_rmask got %h want 0", imem_rmask); end
      if (fetch_1_reg !== '0) begin failures++; $display("FAIL rst_reg got %h want 0", fetch_1_reg); end
      rst = 1'b0;
      #1;
      checks += 2;
      if (imem_rmask !== 4'hF) begin failures++; $display("FAIL first_issue_rmask got %h want f", imem_rmask); end
      if (imem_addr !== RPC) begin failures++; $display("FAIL first_issue_addr got %h want %h", imem_addr, RPC); end
   endtask

   task automatic test_sequential();
      do_reset();
      imem_resp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks += 2;
         if (imem_addr !== RPC + 32'(4 * i)) begin failures++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, RPC + 32'(4 * i)); end
         if (imem_rmask !== 4'hF) begin failures++; $display("FAIL seq_rmask[%0d] got %h want f", i, imem_rmask); end
         clk_step();
         checks++;
         if (fetch_1_reg !== {1'b1, RPC + 32'(4 * i), 1'b0}) begin
            failures++; $display("FAIL seq_reg[%0d] got %h want pc %h valid", i, fetch_1_reg, RPC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      imem_resp = 1'b1;
      clk_step();
      clk_step();
      imem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks += 2;
         if (imem_rmask !== 4'h0) begin failures++; $display("FAIL stall_rmask[%0d] got %h want 0", i, imem_rmask); end
         if (imem_addr !== RPC + 32'h8) begin failures++; $display("FAIL stall_addr[%0d] got %h want %h", i, imem_addr, RPC + 32'h8); end
         clk_step();
         checks++;
         if (fetch_1_reg.pc !== RPC + 32'h4 || fetch_1_reg.valid !== 1'b1) begin
            failures++; $display("FAIL stall_reg[%0d] got %h want pc %h", i, fetch_1_reg, RPC + 32'h4);
         end
      end
      imem_stall = 1'b0;
      #1;
      checks++;
      if (imem_rmask !== 4'hF) begin failures++; $display("FAIL stall_resume got %h want f", imem_rmask); end
   endtask

   task automatic test_mispredict_drain();
      do_reset();
      clk_step();
      branch_mispredict = 1'b1;
      redirect_pc       = RPC + 32'h100;
      #1;
      checks++;
      if (imem_rmask !== 4'h0) begin failures++; $display("FAIL mp_rmask got %h want 0", imem_rmask); end
      clk_step();
      checks += 2;
      if (fetch_1_reg.valid !== 1'b0) begin failures++; $display("FAIL mp_flush got %b want 0", fetch_1_reg.valid); end
      if (imem_addr !== RPC + 32'h100) begin failures++; $display("FAIL mp_addr got %h want %h", imem_addr, RPC + 32'h100); end
      branch_mispredict = 1'b0;
      #1;
      checks++;
      if (imem_rmask !== 4'h0) begin failures++; $display("FAIL drain_rmask got %h want 0", imem_rmask); end
      clk_step();
      imem_resp = 1'b1;
      #1;
      checks += 2;
      if (imem_rmask !== 4'h0) begin failures++; $display("FAIL drain_resp_rmask got %h want 0", imem_rmask); end
      if (fetch_1_reg.valid !== 1'b0) begin failures++; $display("FAIL drain_valid got %b want 0", fetch_1_reg.valid); end
      clk_step();
      imem_resp = 1'b0;
      #1;
      checks += 2;
      if (imem_rmask !== 4'hF) begin failures++; $display("FAIL post_drain_rmask got %h want f", imem_rmask); end
      if (imem_addr !== RPC + 32'h100) begin failures++; $display("FAIL post_drain_addr got %h want %h", imem_addr, RPC + 32'h100); end
      clk_step();
      checks++;
      if (fetch_1_reg !== {1'b1, RPC + 32'h100, 1'b0}) begin failures++; $display("FAIL post_drain_reg got %h want pc %h", fetch_1_reg, RPC + 32'h100); end
   endtask

   task automatic test_btb_taken();
      do_reset();
      imem_resp  = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = RPC + 32'h10;
      upd_target = RPC + 32'h40;
      upd_taken  = 1'b1;
      clk_step();
      idle();
      imem_resp = 1'b1;
      clk_step();
      clk_step();
      clk_step();
      checks++;
      if (imem_addr !== RPC + 32'h10) begin failures++; $display("FAIL taken_reach got %h want %h", imem_addr, RPC + 32'h10); end
      clk_step();
      checks += 2;
      if (fetch_1_reg !== {1'b1, RPC + 32'h10, 1'b1}) begin failures++; $display("FAIL taken_pred got %h want pc %h pred 1", fetch_1_reg, RPC + 32'h10); end
      if (imem_addr !== RPC + 32'h40) begin failures++; $display("FAIL taken_target got %h want %h", imem_addr, RPC + 32'h40); end
   endtask

   // Relies on the BTB entry installed by test_btb_taken.
   task automatic test_btb_not_taken();
      upd_valid = 1'b1;
      upd_pc    = RPC + 32'h10;
      upd_taken = 1'b0;
      clk_step();
      clk_step();
      upd_valid         = 1'b0;
      branch_mispredict = 1'b1;
      redirect_pc       = RPC + 32'h10;
      clk_step();
      branch_mispredict = 1'b0;
      #1;
      checks += 2;
      if (imem_addr !== RPC + 32'h10) begin failures++; $display("FAIL nt_redirect got %h want %h", imem_addr, RPC + 32'h10); end
      if (imem_rmask !== 4'hF) begin failures++; $display("FAIL nt_rmask got %h want f (drain entered)", imem_rmask); end
      clk_step();
      checks += 2;
      if (fetch_1_reg !== {1'b1, RPC + 32'h10, 1'b0}) begin failures++; $display("FAIL nt_pred got %h want pc %h pred 0", fetch_1_reg, RPC + 32'h10); end
      if (imem_addr !== RPC + 32'h14) begin failures++; $display("FAIL nt_next got %h want %h", imem_addr, RPC + 32'h14); end
      upd_valid  = 1'b1;
      upd_pc     = RPC + 32'h20;
      upd_target = RPC + 32'h80;
      upd_taken  = 1'b0;
      clk_step();
      upd_valid = 1'b0;
      clk_step();
      clk_step();
      checks++;
      if (imem_addr !== RPC + 32'h20) begin failures++; $display("FAIL miss_reach got %h want %h", imem_addr, RPC + 32'h20); end
      clk_step();
      checks += 2;
      if (fetch_1_reg.branch_pred !== 1'b0) begin failures++; $display("FAIL miss_alloc_pred got %b want 0", fetch_1_reg.branch_pred); end
      if (imem_addr !== RPC + 32'h24) begin failures++; $display("FAIL miss_alloc_next got %h want %h", imem_addr, RPC + 32'h24); end
   endtask

   task automatic test_reset_in_drain();
      do_reset();
      upd_valid  = 1'b1;
      upd_pc     = RPC + 32'h10;
      upd_target = RPC + 32'h40;
      upd_taken  = 1'b1;
      clk_step();
      upd_valid         = 1'b0;
      branch_mispredict = 1'b1;
      redirect_pc       = RPC + 32'h100;
      clk_step();
      branch_mispredict = 1'b0;
      #1;
      checks++;
      if (imem_rmask !== 4'h0) begin failures++; $display("FAIL rd_in_drain got %h want 0", imem_rmask); end
      rst = 1'b1;
      clk_step();
      rst = 1'b0;
      #1;
      checks += 2;
      if (imem_addr !== RPC) begin failures++; $display("FAIL rd_addr got %h want %h", imem_addr, RPC); end
      if (imem_rmask !== 4'hF) begin failures++; $display("FAIL rd_rmask got %h want f", imem_rmask); end
      imem_resp = 1'b1;
      for (int i = 0; i < 4; i++) clk_step();
      checks++;
      if (imem_addr !== RPC + 32'h10) begin failures++; $display("FAIL rd_reach got %h want %h", imem_addr, RPC + 32'h10); end
      clk_step();
      checks += 2;
      if (fetch_1_reg.branch_pred !== 1'b0) begin failures++; $display("FAIL rd_btb_empty got %b want 0", fetch_1_reg.branch_pred); end
      if (imem_addr !== RPC + 32'h14) begin failures++; $display("FAIL rd_next got %h want %h", imem_addr, RPC + 32'h14); end
   endtask

   task automatic test_random();
      logic [31:0] m_pc, m_fpc;
      logic        m_drain, m_valid, m_pred, pred;
      bit          m_bv  [32];
      logic [31:0] m_tag [32];
      logic [31:0] m_tgt [32];
      int          m_ctr [32];
      int          li, ui;
      logic [3:0]  exp_mask;

      do_reset();
      m_pc = RPC; m_fpc = '0; m_drain = 1'b0; m_valid = 1'b0; m_pred = 1'b0;
      for (int k = 0; k < 32; k++) begin
         m_bv[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 0;
      end

      for (int cyc = 0; cyc < 400; cyc++) begin
         imem_stall        = ($urandom % 4) == 0;
         imem_resp         = ($urandom % 2) == 0;
         branch_mispredict = ($urandom % 10) == 0;
         redirect_pc       = RPC + 32'(4 * $urandom_range(0, 47));
         upd_valid         = ($urandom % 3) == 0;
         upd_pc            = RPC + 32'(4 * $urandom_range(0, 47));
         upd_target        = RPC + 32'(4 * $urandom_range(0, 47));
         upd_taken         = ($urandom % 3) != 0;
         #1;

         exp_mask = (!branch_mispredict && !m_drain && !imem_stall) ? 4'hF : 4'h0;
         checks += 2;
         if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_addr[%0d] got %h want %h", cyc, imem_addr, m_pc); end
         if (imem_rmask !== exp_mask) begin failures++; $display("FAIL rnd_rmask[%0d] got %h want %h", cyc, imem_rmask, exp_mask); end

         li   = int'((m_pc >> 2) % 32);
         pred = m_bv[li] && (m_tag[li] == (m_pc >> 7)) && (m_ctr[li] >= 2);

         if (branch_mispredict) begin
            if (!m_drain && m_valid && !imem_resp) m_drain = 1'b1;
            m_pc    = redirect_pc;
            m_valid = 1'b0;
         end else if (m_drain) begin
            if (imem_resp) m_drain = 1'b0;
         end else if (!imem_stall) begin
            m_valid = 1'b1;
            m_fpc   = m_pc;
            m_pred  = pred;
            m_pc    = pred ? m_tgt[li] : m_pc + 32'd4;
         end

         if (upd_valid) begin
            ui = int'((upd_pc >> 2) % 32);
            if (m_bv[ui] && m_tag[ui] == (upd_pc >> 7)) begin
               if (upd_taken) begin
                  m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                  m_tgt[ui] = upd_target;
               end else begin
                  m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
               end
            end else if (upd_taken) begin
               m_bv[ui]  = 1'b1;
               m_tag[ui] = upd_pc >> 7;
               m_tgt[ui] = upd_target;
               m_ctr[ui] = 2;
            end
         end

         clk_step();
         checks++;
         if (fetch_1_reg !== {m_valid, m_fpc, m_pred}) begin
            failures++; $display("FAIL rnd_reg[%0d] got %h want %h", cyc, fetch_1_reg, {m_valid, m_fpc, m_pred});
         end
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_sequential();
      test_stall();
      test_mispredict_drain();
      test_btb_taken();
      test_btb_not_taken();
      test_reset_in_drain();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
